// File: rtl/lsu_mem_port.sv
// Load/store unit bridging single RISC-V load/store requests onto a word-only data memory.
// Sub-word stores are done as read-modify-write; illegal requests get an error response.
module lsu_mem_port #(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] data_q, data_d;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic        err_q, err_d;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    always_comb begin
        req_err = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = req_addr_i[0];
            3'b010:         req_err = (req_addr_i[1:0] != 2'b00);
            default:        req_err = 1'b1;
        endcase
        // Unsigned variants only make sense for loads.
        if (req_we_i && req_funct3_i[2]) req_err = 1'b1;
        if (req_addr_i >= MEM_BYTES) req_err = 1'b1;
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'h000000, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'h0000, half_sel};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        merge_val = data_q;
        if (!funct3_q[0]) begin
            case (addr_q[1:0])
                2'd0:    merge_val[7:0]   = wdata_q[7:0];
                2'd1:    merge_val[15:8]  = wdata_q[7:0];
                2'd2:    merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        err_d        = err_q;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    err_d   = req_err;
                    data_d  = '0;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o = {addr_q[31:2], 2'b00};
                state_d    = RESP;
                if (!we_q) begin
                    data_d = load_val;
                end else if (funct3_q == 3'b010) begin
                    mem_write_o = 1'b1;
                    mem_wdata_o = wdata_q;
                end else begin
                    // Sub-word store: keep the old word for the merge cycle.
                    data_d  = mem_rdata_i;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_write_o = 1'b1;
                mem_wdata_o = merge_val;
                state_d     = RESP;
            end
            default: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = (we_q || err_q) ? '0 : data_q;
                state_d      = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == IDLE) && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                funct3_q <= req_funct3_i;
                we_q     <= req_we_i;
            end
        end
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit on the core side of the word-addressed data memory (asynchronous read, synchronous word write, `addr[13:2]` indexing). Accepts one RISC-V load/store request at a time from the core, converts it into word-aligned memory accesses, and returns a result.
- LB/LBU/LH/LHU: byte/halfword extraction with sign or zero extension.
- SB/SH: read-modify-write into the word-only memory.
- Misaligned, out-of-range or illegal requests are rejected with an error flag and no memory write.

## Interface
Parameters:
- `MEM_BYTES`, 16384: memory size in bytes; any request with `addr >= MEM_BYTES` is an error.

Ports:
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: block can accept a request; high only in IDLE.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, LSBs used for B/H.
- `resp_valid_o` out 1: one-cycle pulse, request complete.
- `resp_rdata_o` out 32: load result; 0 for stores and errors.
- `resp_err_o` out 1: valid with `resp_valid_o`; 1 = request rejected.
- `mem_write_o` out 1: memory write enable.
- `mem_addr_o` out 32: word-aligned memory address, `{addr[31:2],2'b00}`.
- `mem_wdata_o` out 32: word to write.
- `mem_rdata_i` in 32: memory read data, combinational from `mem_addr_o`.

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- Handshake: a request is accepted when `req_valid_i & req_ready_o` at a rising edge.
  - The address, funct3, we and wdata are latched on acceptance.
  - Inputs are ignored outside IDLE.
- Error check at acceptance. An error occurs when any of these holds:
  - H/HU with `addr[0]=1`;
  - W with `addr[1:0]!=0`;
  - funct3 in {011, 110, 111};
  - store with funct3 100/101;
  - `addr >= MEM_BYTES`.
  - On error: IDLE->RESP with `resp_err_o=1`, `resp_rdata_o=0`, no `mem_write_o`.
- Legal requests:
  - IDLE->ACCESS. `mem_addr_o` = latched aligned address in ACCESS and MERGE, 0 in IDLE and RESP.
  - Load: in ACCESS, capture `mem_rdata_i`, then ACCESS->RESP.
    - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
    - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - SW: `mem_write_o=1`, `mem_wdata_o=wdata` in ACCESS, then ACCESS->RESP.
  - SB/SH: in ACCESS, capture `mem_rdata_i` with no write, then ACCESS->MERGE.
    - In MERGE: `mem_write_o=1`, `mem_wdata_o` = captured word with the addressed byte/halfword replaced by `wdata[7:0]`/`wdata[15:0]`; then MERGE->RESP.
- RESP: `resp_valid_o=1` for exactly one cycle, then RESP->IDLE. No response backpressure.
- `mem_write_o` is high for at most one cycle per request and never in IDLE or RESP. `mem_wdata_o` is 0 when `mem_write_o=0`.
- Reset (any time, including mid-RMW):
  - State goes to IDLE immediately.
  - All outputs go to 0, except `req_ready_o`, which goes to 1 after reset deasserts.
  - A pending MERGE write is abandoned, never issued.

## Timing
- Acceptance edge = cycle 0.
- Load / SW: ACCESS in cycle 1, `resp_valid_o` in cycle 2. SW memory write commits at the end of cycle 1.
- SB/SH: ACCESS in cycle 1, MERGE in cycle 2 (write commits at end of cycle 2), `resp_valid_o` in cycle 3.
- Error: `resp_valid_o` in cycle 1.
- `req_ready_o` returns high the cycle after RESP. Maximum throughput is one request per 3 cycles (loads/SW), 4 (SB/SH) or 2 (errors).
- Response outputs hold 0 except in RESP.
- Read data is sampled at the edge ending ACCESS. The memory is assumed not to be written by another agent during a transaction.

## Test plan
- Reset: assert `rst_i` mid-MERGE of SB 0x10 → no write occurs, `mem_write_o=0`, `req_ready_o=1` after release, and word 0x10 is unchanged.
- SW 0x100 ← 0xDEADBEEF, then LW 0x100 → write pulse in cycle 1; the load gives `resp_rdata_o=0xDEADBEEF` at cycle 2, `resp_err_o=0`.
- With word 0x200 = 0x8081_7F01:
  - LB 0x203 → 0xFFFFFF80.
  - LBU 0x203 → 0x00000080.
  - LH 0x202 → 0xFFFF8081.
  - LHU 0x200 → 0x00007F01.
- With word 0x300 = 0x11223344:
  - SB 0x301 ← 0xAB gives 0x1122AB44.
  - SH 0x302 ← 0xCAFE then gives 0xCAFEAB44.
  - In both, a single `mem_write_o` pulse occurs in cycle 2 and `resp_valid_o` in cycle 3.
- Errors, each giving a response in cycle 1 with `resp_err_o=1`, `resp_rdata_o=0` and no write:
  - LW 0x102;
  - SH 0x101;
  - SW 0x4000 (`MEM_BYTES=16384`);
  - store funct3 100;
  - load funct3 011.
- Back-to-back: hold `req_valid_i=1` with LW, SB, LW → each is accepted only when `req_ready_o=1`; responses arrive in order at cycles 2, 6 and 9, and the second LW observes the SB merge.
